// File: rtl/key_debounce3.sv
// key_debounce3: three-key push-button debouncer. Each active-low raw key
// passes through a 2-flop synchroniser and a counter-qualified FSM.
// Ports: sys_clk, sys_rst_n (async, active-low), m_key1..3 (raw, 0=pressed),
// m_key_level (1=pressed), m_key_press / m_key_release (1-cycle strobes).
`timescale 1ns/1ps
module key_debounce3 #(
  parameter int unsigned CNT_MAX = 999_999,
  parameter int unsigned CNT_W   = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       m_key1,
  input  logic       m_key2,
  input  logic       m_key3,
  output logic [2:0] m_key_level,
  output logic [2:0] m_key_press,
  output logic [2:0] m_key_release
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FLT,
    DOWN,
    REL_FLT
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [2:0] key_raw;
  logic [2:0] s1_q;
  logic [2:0] ks_q;

  state_e           st_q  [3];
  state_e           st_d  [3];
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  logic [2:0] lvl_q, lvl_d;
  logic [2:0] prs_q, prs_d;
  logic [2:0] rel_q, rel_d;

  assign key_raw = {m_key3, m_key2, m_key1};

  // Synchroniser idles at 1 so reset looks like "released".
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q <= 3'b111;
      ks_q <= 3'b111;
    end else begin
      s1_q <= key_raw;
      ks_q <= s1_q;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    prs_d = 3'b000;
    rel_d = 3'b000;
    for (int i = 0; i < 3; i++) begin
      unique case (st_q[i])
        IDLE: begin
          if (!ks_q[i]) begin
            st_d[i]  = PRESS_FLT;
            cnt_d[i] = '0;
          end
        end
        PRESS_FLT: begin
          if (ks_q[i]) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CntMax) begin
            st_d[i]  = DOWN;
            cnt_d[i] = '0;
            lvl_d[i] = 1'b1;
            prs_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        DOWN: begin
          if (ks_q[i]) begin
            st_d[i]  = REL_FLT;
            cnt_d[i] = '0;
          end
        end
        REL_FLT: begin
          if (!ks_q[i]) begin
            st_d[i]  = DOWN;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CntMax) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
            lvl_d[i] = 1'b0;
            rel_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          st_d[i]  = IDLE;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
      end
      lvl_q <= 3'b000;
      prs_q <= 3'b000;
      rel_q <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      lvl_q <= lvl_d;
      prs_q <= prs_d;
      rel_q <= rel_d;
    end
  end

  assign m_key_level   = lvl_q;
  assign m_key_press   = prs_q;
  assign m_key_release = rel_q;

endmodule

// File: tb/tb_key_debounce3.sv
// tb_key_debounce3: directed + random soak bench for key_debounce3
// with CNT_MAX=9 and a 20 ns clock.
`timescale 1ns/1ps
module tb_key_debounce3;

  localparam int CNT_MAX = 9;

  logic       clk;
  logic       rst_n;
  logic [2:0] key;
  logic [2:0] lvl;
  logic [2:0] prs;
  logic [2:0] rel;

  int n_chk;
  int n_err;
  bit soak_on;

  key_debounce3 #(
    .CNT_MAX(CNT_MAX),
    .CNT_W  (4)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .m_key1       (key[0]),
    .m_key2       (key[1]),
    .m_key3       (key[2]),
    .m_key_level  (lvl),
    .m_key_press  (prs),
    .m_key_release(rel)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_key(input int idx, input logic v);
    key[idx] = v;
  endtask

  // Called just after an input change: strobe must appear after the
  // 13th rising edge (E12) and be gone after the 14th (E13).
  task automatic wait_strobe(input string tag, input bit is_rel,
                             input logic [2:0] exp_s,
                             input logic [2:0] exp_l);
    logic [5:0] want;
    want = is_rel ? {3'b000, exp_s} : {exp_s, 3'b000};
    repeat (12) begin
      tick();
      chk({tag, "_quiet"}, {prs, rel}, 6'b0);
    end
    tick();
    chk({tag, "_strobe"}, {prs, rel}, want);
    chk({tag, "_lvl"}, lvl, exp_l);
    tick();
    chk({tag, "_fall"}, {prs, rel}, 6'b0);
    chk({tag, "_hold"}, lvl, exp_l);
  endtask

  task automatic soak_key(input int idx, input longint t_end);
    while ($time < t_end) begin
      #(10 * $urandom_range(1, 40));
      drive_key(idx, 1'($urandom_range(0, 1)));
    end
  endtask

  // Reference: count consecutive synchronised samples that disagree
  // with the accepted level; CNT_MAX+2 of them flip the level.
  logic [2:0] m_s1, m_ks, m_lvl, m_prs, m_rel;
  int         m_run [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1  <= 3'b111;
      m_ks  <= 3'b111;
      m_lvl <= 3'b000;
      m_prs <= 3'b000;
      m_rel <= 3'b000;
      for (int i = 0; i < 3; i++) m_run[i] <= 0;
    end else begin
      m_s1 <= key;
      m_ks <= m_s1;
      for (int i = 0; i < 3; i++) begin
        m_prs[i] <= 1'b0;
        m_rel[i] <= 1'b0;
        if ((~m_ks[i]) != m_lvl[i]) begin
          if (m_run[i] + 1 == CNT_MAX + 2) begin
            m_lvl[i] <= ~m_lvl[i];
            m_prs[i] <= ~m_lvl[i];
            m_rel[i] <= m_lvl[i];
            m_run[i] <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
      end
    end
  end

  logic [2:0] p_lvl, p_prs, p_rel;
  initial begin
    p_lvl = 3'b000;
    p_prs = 3'b000;
    p_rel = 3'b000;
  end

  always @(negedge clk) begin
    if (soak_on) begin
      chk("soak_lvl", lvl, m_lvl);
      chk("soak_prs", prs, m_prs);
      chk("soak_rel", rel, m_rel);
      chk("soak_edge", {prs, rel}, {lvl & ~p_lvl, ~lvl & p_lvl});
      chk("soak_wide", {prs & p_prs, rel & p_rel}, 6'b0);
    end
    p_lvl <= lvl;
    p_prs <= prs;
    p_rel <= rel;
  end

  initial begin
    longint t_end;
    n_chk   = 0;
    n_err   = 0;
    soak_on = 1'b0;
    rst_n   = 1'b1;
    key     = 3'b111;

    // 1. reset with random keys
    #1 rst_n = 1'b0;
    #1 chk("rst_async", {lvl, prs, rel}, 9'b0);
    repeat (5) begin
      key = 3'($urandom);
      tick();
      chk("rst_hold", {lvl, prs, rel}, 9'b0);
    end
    key   = 3'b111;
    rst_n = 1'b1;
    repeat (15) begin
      tick();
      chk("rst_idle", {lvl, prs, rel}, 9'b0);
    end

    // 2. clean press/release on key 1
    drive_key(0, 1'b0);
    wait_strobe("p1", 1'b0, 3'b001, 3'b001);
    repeat (26) tick();
    chk("p1_held", {lvl, prs, rel}, {3'b001, 6'b0});
    drive_key(0, 1'b1);
    wait_strobe("r1", 1'b1, 3'b001, 3'b000);

    // 3. bounce on key 2, then settle low
    drive_key(1, 1'b0);
    repeat (4) begin tick(); chk("b2_a", {lvl, prs, rel}, 9'b0); end
    drive_key(1, 1'b1);
    repeat (3) begin tick(); chk("b2_b", {lvl, prs, rel}, 9'b0); end
    drive_key(1, 1'b0);
    repeat (3) begin tick(); chk("b2_c", {lvl, prs, rel}, 9'b0); end
    drive_key(1, 1'b1);
    repeat (3) begin tick(); chk("b2_d", {lvl, prs, rel}, 9'b0); end
    drive_key(1, 1'b0);
    wait_strobe("p2", 1'b0, 3'b010, 3'b010);
    drive_key(1, 1'b1);
    wait_strobe("r2", 1'b1, 3'b010, 3'b000);

    // 4. simultaneous keys
    key = 3'b000;
    wait_strobe("p123", 1'b0, 3'b111, 3'b111);
    drive_key(2, 1'b1);
    wait_strobe("r3", 1'b1, 3'b100, 3'b011);
    key = 3'b111;
    wait_strobe("r12", 1'b1, 3'b011, 3'b000);

    // 5. reset mid-filter (counter=5 after E7) and while DOWN
    drive_key(0, 1'b0);
    repeat (8) tick();
    rst_n = 1'b0;
    #1 chk("rst_flt", {lvl, prs, rel}, 9'b0);
    repeat (2) begin tick(); chk("rst_flt_h", {lvl, prs, rel}, 9'b0); end
    rst_n = 1'b1;
    wait_strobe("rp1", 1'b0, 3'b001, 3'b001);
    repeat (3) tick();
    rst_n = 1'b0;
    #1 chk("rst_down", {lvl, prs, rel}, 9'b0);
    repeat (2) begin tick(); chk("rst_down_h", {lvl, prs, rel}, 9'b0); end
    rst_n = 1'b1;
    wait_strobe("rp2", 1'b0, 3'b001, 3'b001);
    drive_key(0, 1'b1);
    wait_strobe("rr2", 1'b1, 3'b001, 3'b000);

    // 6. random soak against the reference
    @(posedge clk);
    #3;
    soak_on = 1'b1;
    t_end   = $time + 1_000_000;
    fork
      soak_key(0, t_end);
      soak_key(1, t_end);
      soak_key(2, t_end);
    join
    key = 3'b111;
    repeat (30) @(posedge clk);
    @(negedge clk);
    #1 soak_on = 1'b0;
    chk("end_lvl", lvl, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
